seg7_scan: RTL and testbench
============================

// Module: seg7_scan
// PURPOSE
//  Drives a 4-digit multiplexed seven-segment display. Sits directly downstream of
//  the clock divider: its CLK_OUT feeds SCAN_CLK here, which is oversampled in the
//  CLK_IN domain and edge-detected. Each detected edge steps the display to the next
//  digit. A pending/display double buffer makes new values take effect only on frame
//  boundaries, so the display never shows a half-updated value.
// PARAMETERS
//  SEG_ACTIVE_LOW  1  1: SEG and DP are driven low when lit; 0: driven high when lit
//  AN_ACTIVE_LOW   1  1: AN bit is low when its digit is enabled; 0: high when enabled
// PORTS
//  CLK_IN    in   1   system clock; the only clock in this block
//  clr       in   1   synchronous reset, active-high
//  SCAN_CLK  in   1   divided clock from clkdiv; treated as data, never used as a clock
//  DATA_IN   in   16  four hex nibbles; [3:0] = digit 0 (rightmost)
//  DP_IN     in   4   decimal point per digit; bit i = digit i
//  LOAD      in   1   1-cycle strobe; captures DATA_IN/DP_IN into the pending buffer
//  PEND      out  1   1 while the pending buffer holds a value not yet displayed
//  FRAME     out  1   1-cycle pulse on each digit 3->0 wrap
//  AN        out  4   digit enables; exactly one enabled, or none
//  SEG       out  7   segments {g,f,e,d,c,b,a}
//  DP        out  1   decimal point of the active digit
// BEHAVIOUR
//  - Reset (clr high at a CLK_IN edge): AN all disabled, SEG/DP unlit, PEND=0,
//    FRAME=0, display and pending buffers = 0, sync/edge flops = 0, digit index = 3.
//  - SCAN_CLK passes through a 2-flop synchronizer plus a previous-value flop.
//  - tick = sync2 & ~prev. A SCAN_CLK rise first sampled at edge t produces tick in
//    the cycle after edge t+2. Index, AN, SEG and DP update at edge t+3, all registered.
//  - On tick: index advances 0->1->2->3->0. AN enables the digit at the new index.
//    SEG = hex decode of that digit's nibble; DP = its DP bit.
//  - Hex decode (a..g lit; 1 = lit before polarity is applied):
//    0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
//  - Frame boundary = a tick with index==3.
//    - FRAME pulses for 1 cycle at edge t+3.
//    - If PEND=1, display <= pending and PEND clears on the same edge.
//    - Digit 0 of the new frame already shows the new value.
//    - The first tick after reset is a frame boundary, so digit 0 is shown first.
//  - LOAD sets pending <= {DP_IN, DATA_IN} and PEND=1.
//    - LOAD while PEND=1: overwrite, last value wins.
//    - LOAD on the same edge as a transfer: the old pending goes to display, the new
//      value goes to pending, and PEND stays 1.
//  - No tick: all outputs hold. SCAN_CLK stuck at either level: display frozen on
//    its current digit.
//  - clr mid-frame: immediate return to the reset state on that edge. Any pending
//    value is discarded.
//  - Polarity parameters are applied only at the output registers.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Digit i (i = 3, 2, 1) is blanked (AN disabled in its slot, SEG/DP unlit) when
//      nibbles i..3 are all 0 and DP bits i..3 are all 0.
//    - Digit 0 is never blanked.
//    - The index still steps through the blanked slot, so scan timing is unchanged.
//  LEADING_ZERO_BLANK_EN undefined: all four digits are always displayed.
// TESTING
//  1. clr=1, 3 cycles -> AN=1111, SEG=7F, DP=1, PEND=0, FRAME=0 (default polarity).
//  2. LOAD with DATA_IN=16'h12AF, DP_IN=4'b0100, then 4 SCAN_CLK rises:
//     -> FRAME on the 1st rise only; then AN=1110/SEG=0E (F), 1101/08 (A),
//     1011/24 (2) with DP=0, 0111/79 (1).
//  3. LOAD 16'h1111, then LOAD 16'h2222 before the next wrap -> PEND=1 until the wrap;
//     after the wrap all digits show 2 (SEG=24) and PEND=0.
//  4. SCAN_CLK rise sampled at edge t -> AN changes exactly at edge t+3; SCAN_CLK
//     held high 50 cycles -> only one step.
//  5. clr pulsed while digit 2 is active with PEND=1 -> reset state, PEND=0; the next
//     rise shows digit 0 = 0 (SEG=40).
//  6. LEADING_ZERO_BLANK_EN, DATA_IN=16'h0050, DP_IN=0 -> digits 3 and 2 have AN
//     disabled in their slots; digit 1 shows 5, digit 0 shows 0.

Source files
------------

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed seven-segment display driver.
// SCAN_CLK is oversampled in the CLK_IN domain; each detected rising edge
// advances the display to the next digit. New values pass through a
// pending/display double buffer, so they only take effect at a frame boundary.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        CLK_IN,
    input  logic        clr,
    input  logic        SCAN_CLK,
    input  logic [15:0] DATA_IN,
    input  logic [3:0]  DP_IN,
    input  logic        LOAD,
    output logic        PEND,
    output logic        FRAME,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    // Unlit/disabled output levels after polarity is applied
    localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

    logic        sync1, sync2, prev, tick;
    logic [1:0]  idx;
    logic [19:0] pending, display;

    logic [1:0]  next_idx;
    logic        boundary;
    logic [19:0] src;
    logic [15:0] src_data;
    logic [3:0]  src_dp;
    logic [3:0]  nib;
    logic        dp_bit;
    logic        blank;
    logic [6:0]  lit_seg;
    logic [3:0]  an_onehot;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Select the digit that becomes active on the next tick; at a frame boundary with a pending value, show the new value immediately
    always_comb begin
        next_idx  = idx + 2'd1;
        boundary  = tick && (idx == 2'd3);
        src       = (boundary && PEND) ? pending : display;
        src_data  = src[15:0];
        src_dp    = src[19:16];
        nib       = src_data[{next_idx, 2'b00} +: 4];
        dp_bit    = src_dp[next_idx];
        lit_seg   = hex_decode(nib);
        an_onehot = 4'b0001 << next_idx;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a non-rightmost digit when it and every digit to its left are zero with no decimal point
    always_comb begin
        blank = 1'b0;
        if (next_idx != 2'd0) begin
            blank = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if ((k >= int'(next_idx)) && ((src_data[4*k +: 4] != 4'h0) || src_dp[k])) begin
                    blank = 1'b0;
                end
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Synchronize SCAN_CLK, detect its rising edge, step the scan and manage the double buffer
    always_ff @(posedge CLK_IN) begin
        if (clr) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            tick    <= 1'b0;
            idx     <= 2'd3;
            pending <= 20'h0;
            display <= 20'h0;
            PEND    <= 1'b0;
            FRAME   <= 1'b0;
            AN      <= AN_OFF;
            SEG     <= SEG_OFF;
            DP      <= DP_OFF;
        end else begin
            sync1 <= SCAN_CLK;
            sync2 <= sync1;
            prev  <= sync2;
            tick  <= sync2 & ~prev;
            FRAME <= boundary;

            if (tick) begin
                idx <= next_idx;
                if (blank) begin
                    AN  <= AN_OFF;
                    SEG <= SEG_OFF;
                    DP  <= DP_OFF;
                end else begin
                    AN  <= AN_ACTIVE_LOW  ? ~an_onehot : an_onehot;
                    SEG <= SEG_ACTIVE_LOW ? ~lit_seg   : lit_seg;
                    DP  <= SEG_ACTIVE_LOW ? ~dp_bit    : dp_bit;
                end
            end

            if (boundary && PEND) begin
                display <= pending;
            end

            if (LOAD) begin
                pending <= {DP_IN, DATA_IN};
                PEND    <= 1'b1;
            end else if (boundary) begin
                PEND    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed self-checking bench for seg7_scan (default polarity).
// Build with LEADING_ZERO_BLANK_EN defined to exercise leading-zero blanking.
module tb_seg7_scan;

    logic        CLK_IN;
    logic        clr;
    logic        SCAN_CLK;
    logic [15:0] DATA_IN;
    logic [3:0]  DP_IN;
    logic        LOAD;
    logic        PEND;
    logic        FRAME;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;

    int n_cmp  = 0;
    int n_fail = 0;

    seg7_scan dut (
        .CLK_IN   (CLK_IN),
        .clr      (clr),
        .SCAN_CLK (SCAN_CLK),
        .DATA_IN  (DATA_IN),
        .DP_IN    (DP_IN),
        .LOAD     (LOAD),
        .PEND     (PEND),
        .FRAME    (FRAME),
        .AN       (AN),
        .SEG      (SEG),
        .DP       (DP)
    );

    // Free-running system clock
    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_digit(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e, input logic dp_e);
        check_output({tag, "_an"},  20'(AN),  20'(an_e));
        check_output({tag, "_seg"}, 20'(SEG), 20'(seg_e));
        check_output({tag, "_dp"},  20'(DP),  20'(dp_e));
    endtask

    // Low for 3 cycles, then a rise held through edge t+3 so outputs have just updated
    task automatic scan_rise();
        SCAN_CLK = 1'b0;
        repeat (3) step();
        SCAN_CLK = 1'b1;
        repeat (4) step();
    endtask

    task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] p);
        DATA_IN = d;
        DP_IN   = p;
        LOAD    = 1'b1;
        step();
        LOAD    = 1'b0;
    endtask

    initial begin
        $display("[TB] seg7_scan bench start");
        clr = 1'b1; LOAD = 1'b0; SCAN_CLK = 1'b0; DATA_IN = 16'h0; DP_IN = 4'h0;
        repeat (3) step();
        check_digit("reset", 4'hF, 7'h7F, 1'b1);
        check_output("reset_pend",  20'(PEND),  20'h0);
        check_output("reset_frame", 20'(FRAME), 20'h0);
        clr = 1'b0;
        step();

        // Basic frame: 12AF with DP on digit 2
        apply_stimulus(16'h12AF, 4'b0100);
        check_output("load_pend", 20'(PEND), 20'h1);
        scan_rise();
        check_output("d0_frame", 20'(FRAME), 20'h1);
        check_output("d0_pend",  20'(PEND),  20'h0);
        check_digit("d0", 4'hE, 7'h0E, 1'b1);
        step();
        check_output("frame_pulse_end", 20'(FRAME), 20'h0);
        scan_rise();
        check_output("d1_frame", 20'(FRAME), 20'h0);
        check_digit("d1", 4'hD, 7'h08, 1'b1);
        scan_rise();
        check_digit("d2", 4'hB, 7'h24, 1'b0);
        scan_rise();
        check_digit("d3", 4'h7, 7'h79, 1'b1);

        // Overwrite while pending: last value wins
        apply_stimulus(16'h1111, 4'h0);
        apply_stimulus(16'h2222, 4'h0);
        check_output("ovw_pend", 20'(PEND), 20'h1);
        scan_rise();
        check_output("ovw_frame", 20'(FRAME), 20'h1);
        check_output("ovw_pend_clr", 20'(PEND), 20'h0);
        check_digit("ovw_d0", 4'hE, 7'h24, 1'b1);
        scan_rise();
        check_digit("ovw_d1", 4'hD, 7'h24, 1'b1);
        scan_rise();
        check_digit("ovw_d2", 4'hB, 7'h24, 1'b1);
        scan_rise();
        check_digit("ovw_d3", 4'h7, 7'h24, 1'b1);

        // LOAD on the same edge as the transfer: old pending shown, new one stays pending
        apply_stimulus(16'h3333, 4'h0);
        SCAN_CLK = 1'b0;
        repeat (3) step();
        SCAN_CLK = 1'b1;
        repeat (3) step();
        DATA_IN = 16'h4444;
        LOAD    = 1'b1;
        step();
        LOAD    = 1'b0;
        check_output("coll_frame", 20'(FRAME), 20'h1);
        check_output("coll_pend",  20'(PEND),  20'h1);
        check_digit("coll_d0", 4'hE, 7'h30, 1'b1);
        scan_rise();
        scan_rise();
        scan_rise();
        check_digit("coll_d3", 4'h7, 7'h30, 1'b1);
        scan_rise();
        check_output("coll2_pend", 20'(PEND), 20'h0);
        check_digit("coll2_d0", 4'hE, 7'h19, 1'b1);

        // Latency: rise first sampled at edge t changes AN exactly at t+3
        SCAN_CLK = 1'b0;
        repeat (3) step();
        SCAN_CLK = 1'b1;
        repeat (3) step();
        check_output("lat_t2_an", 20'(AN), 20'hE);
        step();
        check_output("lat_t3_an", 20'(AN), 20'hD);
        repeat (46) step();
        check_output("held_high_an", 20'(AN), 20'hD);

        // clr mid-frame with a pending value discards it
        scan_rise();
        check_output("pre_clr_an", 20'(AN), 20'hB);
        apply_stimulus(16'h5555, 4'h0);
        check_output("pre_clr_pend", 20'(PEND), 20'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_digit("clr", 4'hF, 7'h7F, 1'b1);
        check_output("clr_pend", 20'(PEND), 20'h0);
        scan_rise();
        check_output("post_clr_frame", 20'(FRAME), 20'h1);
        check_digit("post_clr_d0", 4'hE, 7'h40, 1'b1);

        // Leading zeros: 0050 with no decimal points
        apply_stimulus(16'h0050, 4'h0);
        scan_rise();
        scan_rise();
        scan_rise();
        scan_rise();
        check_digit("lz_d0", 4'hE, 7'h40, 1'b1);
        scan_rise();
        check_digit("lz_d1", 4'hD, 7'h12, 1'b1);
        scan_rise();
`ifdef LEADING_ZERO_BLANK_EN
        check_digit("lz_d2", 4'hF, 7'h7F, 1'b1);
        scan_rise();
        check_digit("lz_d3", 4'hF, 7'h7F, 1'b1);
`else
        check_digit("lz_d2", 4'hB, 7'h40, 1'b1);
        scan_rise();
        check_digit("lz_d3", 4'h7, 7'h40, 1'b1);
`endif
        scan_rise();
        check_digit("lz_wrap_d0", 4'hE, 7'h40, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
